serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial, LSB-first ripple adder; the additive counterpart to the team's combinational half/full subtractor building blocks.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Computes one sum bit per clock through a single full-adder cell and a registered carry.
- Presents sum and carry-out over a valid/ready output handshake; used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a/b/cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, counter=0, carry=0, shift registers=0. Outputs after reset: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- Reset has priority over every other event, including mid-RUN. A partial result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load a_sh=a, b_sh=b, carry=cin, counter=0, clear the sum shift register, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the full adder takes a_sh[0], b_sh[0] and carry.
  - The sum bit shifts into sum_sh from the MSB side (right shift), so after WIDTH cycles bit0 sits at position 0.
  - a_sh and b_sh shift right by 1, carry takes the full-adder carry, counter increments.
  - When counter==WIDTH-1, that cycle's bit is the last: go to DONE.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry.
  - On out_ready, go to IDLE. Otherwise hold; sum and cout stay stable while out_valid&!out_ready.
- Latency: operands accepted at edge E0; out_valid is high after edge E0+WIDTH. Throughput is one result per WIDTH+2 cycles at best.
- No overlap: in_ready=0 in RUN and DONE. in_valid is ignored there, and a/b/cin may change freely after acceptance.
- sum and cout hold the last result in IDLE (not cleared) until the next result lands.
- Arithmetic: unsigned. {cout,sum} = a+b+cin, exact over WIDTH+1 bits. Counter wraps to 0 on leaving RUN.
- out_ready high in IDLE or RUN has no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit). Reset value is 0.
  - ovf is registered on the final RUN cycle as carry_into_msb XOR carry_out_of_msb, i.e. two's-complement signed overflow.
  - ovf is valid with out_valid and holds with sum.
- Undefined: no ovf port and no associated flops; behaviour otherwise identical.

Decomposition:
- Package serial_adder_pkg:
  - state_e enum {IDLE, RUN, DONE}, 2-bit logic.
  - localparam function for the counter width.
- Sub-module full_adder:
  - Combinational inputs x, y, ci; outputs s, co.
  - s = x^y^ci; co = (x&y)|(ci&(x^y)).
  - Instantiated once.

Test Plan (WIDTH=8):
- Basic add: a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=0x96, cout=0; in_ready returns 1 the cycle after the output handshake.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Backpressure: a=0x12, b=0x34, out_ready held 0 for 5 cycles after out_valid -> sum=0x46 stable all 5 cycles, out_valid stays 1. A new in_valid with a=0xAA during DONE is ignored (in_ready=0).
- Reset mid-operation: accept a=0x80, b=0x80, drop rst_n at the 4th RUN cycle -> next cycle state IDLE, out_valid=0, sum=0, cout=0, in_ready=1. Then a=0x01, b=0x02 -> sum=0x03.
- Random soak: 1000 random a/b/cin with random out_ready -> {cout,sum}==a+b+cin every transaction; no accept while busy=1.
- With SERIAL_ADDER_OVERFLOW_EN:
  - a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0.
  - a=0xFF, b=0x01 -> ovf=0, cout=1.
  - a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter-width helper for serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational full adder cell.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_co, last, accept, run, finish;
    logic [WIDTH-1:0] sh_next;

    full_adder u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .ci(carry_q),
        .s (fa_s),
        .co(fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (in_valid  ? RUN  : IDLE) :
                  (state_q == RUN)  ? (last      ? DONE : RUN)  :
                                      (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
    end

    // Result registers load only on the final bit so sum/cout hold the last result while idle.
    always_comb begin
        last    = cnt_q == CNT_W'(WIDTH - 1);
        accept  = (state_q == IDLE) && in_valid;
        run     = state_q == RUN;
        finish  = run && last;
        sh_next = {fa_s, sh_q[WIDTH-1:1]};
        a_d     = accept ? a   : run ? a_q >> 1 : a_q;
        b_d     = accept ? b   : run ? b_q >> 1 : b_q;
        carry_d = accept ? cin : run ? fa_co    : carry_q;
        cnt_d   = (run && !last) ? cnt_q + CNT_W'(1) : '0;
        sh_d    = accept ? '0  : run ? sh_next  : sh_q;
        sum_d   = finish ? sh_next : sum_q;
        cout_d  = finish ? fa_co   : cout_q;
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (finish) ovf_q <= carry_q ^ fa_co;
    end
    assign ovf = ovf_q;
`endif

endmodule
